// File: rtl/cpu_pkg.sv
// Shared CPU widths and the write-port result record used by the RF write arbiter.
package cpu_pkg;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wd;
  } wb_res_t;

  // Used only by checkers that compare the scoreboard against its counter.
  function automatic int popcount(input logic [NREGS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of WB, MDU, decode and register-file signals around the RF write arbiter.
interface rf_wb_arbiter_if #(parameter int MAX_OUT = 4);
  import cpu_pkg::*;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic             wb_we;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_wd;
  logic             mdu_issue;
  logic [REG_W-1:0] mdu_issue_rd;
  logic             mdu_valid;
  logic [REG_W-1:0] mdu_rd;
  logic [XLEN-1:0]  mdu_wd;
  logic             mdu_ready;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_we;
  logic             stall;
  logic             RFWr;
  logic [REG_W-1:0] A3;
  logic [XLEN-1:0]  WD;
  logic [CNT_W-1:0] pend_cnt;

  modport master (
    output wb_we, wb_rd, wb_wd, mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_wd,
           id_rs1, id_rs2, id_rd, id_rd_we,
    input  mdu_ready, stall, RFWr, A3, WD, pend_cnt
  );

  modport slave (
    input  wb_we, wb_rd, wb_wd, mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_wd,
           id_rs1, id_rs2, id_rd, id_rd_we,
    output mdu_ready, stall, RFWr, A3, WD, pend_cnt
  );
endinterface

// File: rtl/wb_res_fifo.sv
// Small FIFO holding MDU results that lost the RF write port to the WB stage.
module wb_res_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_res_t din,
  output wb_res_t head,
  output logic    empty,
  output logic    full
);
  localparam int AW = $clog2(DEPTH);

  // Extra pointer MSB tells full from empty when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_res_t     mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port between WB and the MDU, and tracks outstanding
// MDU destinations to stall decode on hazards, the outstanding limit and starvation.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic             wb_gnt;
  logic             port_free;
  logic             ready;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             mdu_wr;
  logic             set_pend;
  logic [REG_W-1:0] clr_rd;
  wb_res_t          head;
  wb_res_t          mdu_res;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_nxt;

  assign mdu_res = '{rd: bus.mdu_rd, wd: bus.mdu_wd};

  wb_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (mdu_res),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    wb_gnt    = bus.wb_we && (bus.wb_rd != '0);
    port_free = !wb_gnt;
    ready     = rst_n && !full;
    accept    = bus.mdu_valid && ready;
    // A result may only skip the FIFO when nothing older is waiting.
    bypass    = accept && (bus.mdu_rd != '0) && empty && port_free;
    push      = accept && (bus.mdu_rd != '0) && !bypass;
    pop       = rst_n && !empty && port_free;
    mdu_wr    = pop || bypass;
    clr_rd    = pop ? head.rd : bus.mdu_rd;
    set_pend  = bus.mdu_issue && (bus.mdu_issue_rd != '0);
  end

  always_comb begin
    bus.RFWr = 1'b0;
    bus.A3   = '0;
    bus.WD   = '0;
    if (rst_n) begin
      if (wb_gnt) begin
        bus.RFWr = 1'b1;
        bus.A3   = bus.wb_rd;
        bus.WD   = bus.wb_wd;
      end else if (!empty) begin
        bus.RFWr = 1'b1;
        bus.A3   = head.rd;
        bus.WD   = head.wd;
      end else if (bypass) begin
        bus.RFWr = 1'b1;
        bus.A3   = bus.mdu_rd;
        bus.WD   = bus.mdu_wd;
      end
    end
  end

  // Set is applied after clear so a re-issue to the retiring register stays pending.
  always_comb begin
    pend_nxt = pend;
    if (mdu_wr)   pend_nxt[clr_rd]           = 1'b0;
    if (set_pend) pend_nxt[bus.mdu_issue_rd] = 1'b1;
    case ({set_pend, mdu_wr})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
    if (empty || pop)        age_nxt = '0;
    else if (age != AGE_MAX) age_nxt = age + 1'b1;
    else                     age_nxt = age;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
      age  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
      age  <= age_nxt;
    end
  end

  always_comb begin
    bus.stall = rst_n && (
                  ((bus.id_rs1 != '0) && pend[bus.id_rs1]) ||
                  ((bus.id_rs2 != '0) && pend[bus.id_rs2]) ||
                  (bus.id_rd_we && (bus.id_rd != '0) && pend[bus.id_rd]) ||
                  (cnt == CNT_MAX) ||
                  (age >= AGE_MAX));
  end

  assign bus.mdu_ready = ready;
  assign bus.pend_cnt  = cnt;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes queued as stimulus is driven.
module tb_rf_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH        = 2;
  localparam int MAX_OUT      = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rf_wb_arbiter_if #(.MAX_OUT(MAX_OUT)) bus ();

  rf_wb_arbiter #(
    .DEPTH        (DEPTH),
    .MAX_OUT      (MAX_OUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  wb_res_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] wd);
    exp_q.push_back('{rd: rd, wd: wd});
  endtask

  task automatic idle();
    bus.wb_we        = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_wd        = '0;
    bus.mdu_issue    = 1'b0;
    bus.mdu_issue_rd = '0;
    bus.mdu_valid    = 1'b0;
    bus.mdu_rd       = '0;
    bus.mdu_wd       = '0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_rd        = '0;
    bus.id_rd_we     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    bus.mdu_issue    = 1'b1;
    bus.mdu_issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] wd);
    bus.wb_we = 1'b1;
    bus.wb_rd = rd;
    bus.wb_wd = wd;
  endtask

  task automatic mdu(input logic [4:0] rd, input logic [31:0] wd);
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = rd;
    bus.mdu_wd    = wd;
  endtask

  // Mid-cycle sample: RF write against the scoreboard, plus standing invariants.
  task automatic settle();
    wb_res_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rfwr", bus.RFWr, 1);
      chk("a3", bus.A3, e.rd);
      chk("wd", bus.WD, e.wd);
    end else begin
      chk("rfwr_idle", bus.RFWr, 0);
    end
    chk("pend_popcount", bus.pend_cnt, popcount(dut.pend));
    if (bus.mdu_issue) chk("issue_no_stall", bus.stall, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    wb(5'd3, 32'h55);
    settle();
    chk("rst_ready", bus.mdu_ready, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_cnt", bus.pend_cnt, 0);
    next();
    rst_n = 1'b1;
    idle();
    settle();
    chk("post_rst_ready", bus.mdu_ready, 1);
    chk("post_rst_stall", bus.stall, 0);
    next();

    // bypass of a result straight to the RF
    issue(5'd5);
    settle();
    next();
    idle(); bus.id_rs1 = 5'd5;
    settle();
    chk("raw_before", bus.stall, 1);
    chk("cnt_one", bus.pend_cnt, 1);
    next();
    idle(); bus.id_rs1 = 5'd5; mdu(5'd5, 32'hDEAD_BEEF); exp_wr(5'd5, 32'hDEAD_BEEF);
    settle();
    chk("bypass_ready", bus.mdu_ready, 1);
    next();
    idle(); bus.id_rs1 = 5'd5;
    settle();
    chk("raw_after", bus.stall, 0);
    chk("cnt_zero_bypass", bus.pend_cnt, 0);
    next();

    // WB wins the port, MDU result queued then drained
    issue(5'd7);
    settle();
    next();
    idle(); wb(5'd3, 32'h11); mdu(5'd7, 32'h22); exp_wr(5'd3, 32'h11);
    settle();
    chk("conflict_ready", bus.mdu_ready, 1);
    next();
    idle(); exp_wr(5'd7, 32'h22);
    settle();
    next();
    idle();
    settle();
    chk("cnt_zero_conflict", bus.pend_cnt, 0);
    next();

    // fill the FIFO behind WB, back-pressure, then in-order drain
    for (int r = 8; r <= 10; r++) begin
      issue(5'(r));
      settle();
      next();
    end
    idle(); wb(5'd1, 32'hA1); mdu(5'd8, 32'h80); exp_wr(5'd1, 32'hA1);
    settle();
    chk("fill1_ready", bus.mdu_ready, 1);
    next();
    wb(5'd1, 32'hA2); mdu(5'd9, 32'h90); exp_wr(5'd1, 32'hA2);
    settle();
    chk("fill2_ready", bus.mdu_ready, 1);
    next();
    wb(5'd1, 32'hA3); mdu(5'd10, 32'hA0); exp_wr(5'd1, 32'hA3);
    settle();
    chk("full_ready", bus.mdu_ready, 0);
    next();
    bus.wb_we = 1'b0; exp_wr(5'd8, 32'h80);
    settle();
    chk("drain_full_ready", bus.mdu_ready, 0);
    next();
    exp_wr(5'd9, 32'h90);
    settle();
    chk("drain_push_pop_ready", bus.mdu_ready, 1);
    next();
    idle(); exp_wr(5'd10, 32'hA0);
    settle();
    next();
    idle();
    settle();
    chk("cnt_zero_full", bus.pend_cnt, 0);
    chk("stall_zero_full", bus.stall, 0);
    next();

    // starvation: queued head behind a long WB burst
    issue(5'd12);
    settle();
    next();
    for (int k = 0; k < 10; k++) begin
      idle(); wb(5'd4, 32'(k));
      if (k == 0) mdu(5'd12, 32'hC0);
      exp_wr(5'd4, 32'(k));
      settle();
      chk($sformatf("starve_stall_%0d", k), bus.stall, (k >= 9) ? 1 : 0);
      next();
    end
    idle(); exp_wr(5'd12, 32'hC0);
    settle();
    chk("starve_pop_stall", bus.stall, 1);
    next();
    idle();
    settle();
    chk("starve_release", bus.stall, 0);
    chk("cnt_zero_starve", bus.pend_cnt, 0);
    next();

    // outstanding limit and hazards
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r));
      settle();
      next();
    end
    idle(); bus.id_rs1 = 5'd20;
    settle();
    chk("limit_stall", bus.stall, 1);
    chk("limit_cnt", bus.pend_cnt, 4);
    next();
    idle(); mdu(5'd1, 32'h1111); exp_wr(5'd1, 32'h1111);
    settle();
    next();
    idle(); bus.id_rs1 = 5'd20;
    settle();
    chk("below_limit", bus.stall, 0);
    chk("cnt_three", bus.pend_cnt, 3);
    next();
    idle(); bus.id_rd_we = 1'b1; bus.id_rd = 5'd2;
    settle();
    chk("waw_stall", bus.stall, 1);
    next();
    idle(); bus.id_rd = 5'd2;
    settle();
    chk("rd_no_we", bus.stall, 0);
    next();
    idle(); bus.id_rs2 = 5'd2;
    settle();
    chk("raw_rs2", bus.stall, 1);
    next();
    idle(); bus.id_rd_we = 1'b1;
    settle();
    chk("zero_regs", bus.stall, 0);
    next();
    idle(); mdu(5'd0, 32'hBAD);
    settle();
    chk("rd0_ready", bus.mdu_ready, 1);
    next();
    idle();
    settle();
    chk("rd0_cnt", bus.pend_cnt, 3);
    next();
    for (int r = 2; r <= 4; r++) begin
      idle(); mdu(5'(r), 32'(r * 256)); exp_wr(5'(r), 32'(r * 256));
      settle();
      next();
    end
    idle();
    settle();
    chk("cnt_zero_hazard", bus.pend_cnt, 0);
    next();

    // reset with two queued results and pend = 0x104
    issue(5'd2);
    settle();
    next();
    issue(5'd8);
    settle();
    next();
    idle(); wb(5'd1, 32'hB1); mdu(5'd2, 32'h2222); exp_wr(5'd1, 32'hB1);
    settle();
    next();
    wb(5'd1, 32'hB2); mdu(5'd8, 32'h8888); exp_wr(5'd1, 32'hB2);
    settle();
    chk("pre_rst_cnt", bus.pend_cnt, 2);
    next();
    rst_n = 1'b0;
    bus.mdu_valid = 1'b0;
    settle();
    chk("midrst_ready", bus.mdu_ready, 0);
    chk("midrst_cnt", bus.pend_cnt, 0);
    chk("midrst_stall", bus.stall, 0);
    next();
    rst_n = 1'b1;
    idle();
    settle();
    chk("rel_ready", bus.mdu_ready, 1);
    chk("rel_stall", bus.stall, 0);
    chk("rel_cnt", bus.pend_cnt, 0);
    next();
    idle();
    settle();
    next();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
